// File: rtl/scoreboard_button_ctrl.sv
// Scoreboard button front end: turns two raw push buttons into single-cycle
// up/down count pulses with auto-repeat on hold, and a clear pulse when both
// buttons are held long enough. Bit 0 of the per-button vectors is "up",
// bit 1 is "down".
module scoreboard_button_ctrl #(
    parameter int DB_CYCLES     = 1000,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter int CLEAR_HOLD    = 100000,
    parameter int TBW           = 17
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_up_i,
    input  logic btn_down_i,
    output logic up_pulse_o,
    output logic down_pulse_o,
    output logic clear_o
);

    localparam int DBW = $clog2(DB_CYCLES);

    // Compare against "last value before the event" so the counters never
    // need to hold the full threshold value.
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [TBW-1:0] RD_LAST = TBW'(REPEAT_DELAY - 1);
    localparam logic [TBW-1:0] RP_LAST = TBW'(REPEAT_PERIOD - 1);
    localparam logic [TBW-1:0] CH_LAST = TBW'(CLEAR_HOLD - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] UP_HOLD   = 3'd1;
    localparam logic [2:0] DOWN_HOLD = 3'd2;
    localparam logic [2:0] BOTH      = 3'd3;
    localparam logic [2:0] WAIT_REL  = 3'd4;

    logic [1:0]          sync1_d, sync1_q;
    logic [1:0]          sync2_d, sync2_q;
    logic [1:0]          deb_d, deb_q;
    logic [1:0][DBW-1:0] cnt_d, cnt_q;
    logic [2:0]          state_d, state_q;
    logic [TBW-1:0]      timer_d, timer_q;
    logic [TBW-1:0]      timer_inc;
    logic                rep_d, rep_q;
    logic                up_d, up_q;
    logic                dn_d, dn_q;
    logic                clr_d, clr_q;
    logic                up_lvl, dn_lvl;

    // Two-flop synchronizer with nothing between the stages.
    always_comb begin
        sync1_d = {btn_down_i, btn_up_i};
        sync2_d = sync1_q;
    end

    // Debounce: the level flips only after DB_CYCLES consecutive mismatches.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign up_lvl    = deb_q[0];
    assign dn_lvl    = deb_q[1];
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    // Press/hold FSM. The shared timer restarts on every state entry and on
    // each repeat pulse; rep_q selects initial delay versus repeat period.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rep_d   = rep_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_lvl && dn_lvl) begin
                    state_d = BOTH;
                    timer_d = '0;
                end else if (up_lvl) begin
                    up_d    = 1'b1;
                    state_d = UP_HOLD;
                    timer_d = '0;
                    rep_d   = 1'b0;
                end else if (dn_lvl) begin
                    dn_d    = 1'b1;
                    state_d = DOWN_HOLD;
                    timer_d = '0;
                    rep_d   = 1'b0;
                end
            end
            UP_HOLD: begin
                if (!up_lvl) begin
                    state_d = IDLE;
                end else if (dn_lvl) begin
                    state_d = BOTH;
                    timer_d = '0;
                end else if (timer_q == (rep_q ? RP_LAST : RD_LAST)) begin
                    up_d    = 1'b1;
                    timer_d = '0;
                    rep_d   = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            DOWN_HOLD: begin
                if (!dn_lvl) begin
                    state_d = IDLE;
                end else if (up_lvl) begin
                    state_d = BOTH;
                    timer_d = '0;
                end else if (timer_q == (rep_q ? RP_LAST : RD_LAST)) begin
                    dn_d    = 1'b1;
                    timer_d = '0;
                    rep_d   = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            BOTH: begin
                if (!up_lvl || !dn_lvl) begin
                    state_d = WAIT_REL;
                end else if (timer_q == CH_LAST) begin
                    clr_d   = 1'b1;
                    state_d = WAIT_REL;
                end else begin
                    timer_d = timer_inc;
                end
            end
            WAIT_REL: begin
                if (!up_lvl && !dn_lvl) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything including the synchronizers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            rep_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            clr_q   <= clr_d;
        end
    end

    assign up_pulse_o   = up_q;
    assign down_pulse_o = dn_q;
    assign clear_o      = clr_q;

endmodule

// File: tb/tb_scoreboard_button_ctrl.sv
// Directed bench for scoreboard_button_ctrl with DB_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8, CLEAR_HOLD=40. Cycle t=0 is the first
// edge that samples the new button levels; expected pulses are masks over t.
module tb_scoreboard_button_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic up_pulse;
    logic down_pulse;
    logic clear;

    int tests  = 0;
    int failed = 0;

    scoreboard_button_ctrl #(
        .DB_CYCLES    (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8),
        .CLEAR_HOLD   (40),
        .TBW          (17)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_up_i    (btn_up),
        .btn_down_i  (btn_down),
        .up_pulse_o  (up_pulse),
        .down_pulse_o(down_pulse),
        .clear_o     (clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           ncyc;
        int           up_on, up_off, up_on2, up_off2;
        int           dn_on, dn_off, dn_bounce, dn_on2, dn_off2;
        logic [127:0] eu, ed, ec;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [127:0] pm(int a, int b = -1, int c = -1,
                                        int d = -1, int e = -1, int f = -1);
        logic [127:0] m;
        int           l[6];
        m = '0;
        l[0] = a; l[1] = b; l[2] = c; l[3] = d; l[4] = e; l[5] = f;
        for (int i = 0; i < 6; i++)
            if (l[i] >= 0) m[l[i]] = 1'b1;
        return m;
    endfunction

    function automatic logic in_win(int t, int on, int off);
        return (t >= on) && (t < off);
    endfunction

    task automatic chk(string nm, int t, logic eu, logic ed, logic ec);
        tests++;
        if ({up_pulse, down_pulse, clear} !== {eu, ed, ec}) begin
            failed++;
            $display("FAIL %s t=%0d got up/down/clr=%b%b%b expected %b%b%b",
                     nm, t, up_pulse, down_pulse, clear, eu, ed, ec);
        end
    endtask

    initial begin
        tbl[0] = '{"clean_press", 30, 0, 12, -1, -1, -1, -1, 0, -1, -1,
                   pm(6), 128'd0, 128'd0};
        tbl[1] = '{"bounce", 35, -1, -1, -1, -1, 0, 24, 14, -1, -1,
                   128'd0, pm(18), 128'd0};
        tbl[2] = '{"auto_repeat", 70, 0, 60, -1, -1, -1, -1, 0, -1, -1,
                   pm(6, 26, 34, 42, 50, 58), 128'd0, 128'd0};
        tbl[3] = '{"clear", 80, 0, 50, 60, 70, 0, 50, 0, -1, -1,
                   pm(66), 128'd0, pm(46)};
        tbl[4] = '{"aborted_clear", 55, 0, 30, -1, -1, 10, 30, 0, 40, 50,
                   pm(6), pm(46), 128'd0};

        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with both buttons held: outputs stay low throughout.
        @(negedge clk);
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", t, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        // Release reset with up still held: counts as a fresh press.
        rst = 1'b0;
        btn_down = 1'b0;
        for (int t = 0; t < 16; t++) begin
            @(posedge clk);
            #1;
            chk("reset_release", t, t == 6, 1'b0, 1'b0);
            @(negedge clk);
        end

        for (int v = 0; v < 5; v++) begin
            rst = 1'b1;
            btn_up = 1'b0;
            btn_down = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int t = 0; t < tbl[v].ncyc; t++) begin
                btn_up = in_win(t, tbl[v].up_on, tbl[v].up_off) ||
                         in_win(t, tbl[v].up_on2, tbl[v].up_off2);
                if (t < tbl[v].dn_bounce)
                    btn_down = ((t / 2) % 2) == 0;
                else
                    btn_down = in_win(t, tbl[v].dn_on, tbl[v].dn_off) ||
                               in_win(t, tbl[v].dn_on2, tbl[v].dn_off2);
                @(posedge clk);
                #1;
                chk(tbl[v].name, t, tbl[v].eu[t], tbl[v].ed[t], tbl[v].ec[t]);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
